// File: rtl/seg_codes_pkg.sv
// Shared definitions for the segment-pattern reader: the sixteen active-low
// seven-segment codes (bit0 = a .. bit6 = g) and the reader FSM encoding.
package seg_codes_pkg;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h18;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    typedef enum logic {
        COLLECT = 1'b0,
        DONE    = 1'b1
    } reader_state_e;

endpackage

// File: rtl/seg_pattern_lookup.sv
// Combinational inverse of the hex display decoder: maps one active-low
// segment pattern back to its nibble. Anything outside the sixteen known
// glyphs reports known=0 and a nibble of zero.
module seg_pattern_lookup
    import seg_codes_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nib,
    output logic       known
);

    // Table lookup; unknown patterns fall through to the default arm
    always_comb begin
        nib   = 4'h0;
        known = 1'b1;
        case (seg)
            SEG_0: nib = 4'h0;
            SEG_1: nib = 4'h1;
            SEG_2: nib = 4'h2;
            SEG_3: nib = 4'h3;
            SEG_4: nib = 4'h4;
            SEG_5: nib = 4'h5;
            SEG_6: nib = 4'h6;
            SEG_7: nib = 4'h7;
            SEG_8: nib = 4'h8;
            SEG_9: nib = 4'h9;
            SEG_A: nib = 4'hA;
            SEG_B: nib = 4'hB;
            SEG_C: nib = 4'hC;
            SEG_D: nib = 4'hD;
            SEG_E: nib = 4'hE;
            SEG_F: nib = 4'hF;
            default: begin
                nib   = 4'h0;
                known = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seg_pattern_reader.sv
// Segment-pattern reader: collects NUM_DIGITS active-low segment patterns over
// a valid/ready handshake, converts each back to a nibble and packs them, first
// digit in the top nibble, into one word held until the consumer takes it.
// Optional feature: define SEG_READER_TIMEOUT_EN to drop a partial word after
// TIMEOUT_CYCLES idle cycles between digits.
module seg_pattern_reader
    import seg_codes_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic [6:0]              seg_in,
    input  logic                    seg_valid,
    output logic                    seg_ready,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic                    bad_digit,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int W  = 4 * NUM_DIGITS;
    localparam int CW = $clog2(NUM_DIGITS + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_DIGITS - 1);

    reader_state_e state_q, state_d;
    logic [W-1:0]  value_q, value_d;
    logic          bad_q, bad_d;
    logic [CW-1:0] count_q, count_d;

    logic [3:0] lookup_nib;
    logic       lookup_known;
    logic       accept;
    logic       last_digit;
    logic       handshake;
    logic       timeout_expire;

    seg_pattern_lookup u_lookup (
        .seg   (seg_in),
        .nib   (lookup_nib),
        .known (lookup_known)
    );

    assign accept     = seg_valid & seg_ready;
    assign last_digit = (count_q == LAST_IDX);
    assign handshake  = out_valid & out_ready;

`ifdef SEG_READER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] timer_q, timer_d;

    // Idle timer runs only while a partial word is pending; any accept restarts it
    always_comb begin
        timer_d        = '0;
        timeout_expire = 1'b0;
        if ((state_q == COLLECT) && (count_q != '0) && !accept) begin
            if (timer_q == TIMER_LAST) begin
                timeout_expire = 1'b1;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end
    end

    // Idle timer register
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    // No timer in this build; the parameter is referenced only so that both builds share one port/parameter list
    assign timeout_expire = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

    // FSM state register
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: leave COLLECT on the final digit, leave DONE on the consumer handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (accept && last_digit) state_d = DONE;
            DONE:    if (out_ready)            state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    // FSM outputs: ready to take digits only while collecting, word valid only while done
    always_comb begin
        seg_ready = (state_q == COLLECT);
        out_valid = (state_q == DONE);
    end

    // Datapath next state: shift in on accept, clear flags on handshake, drop the partial word on timeout
    always_comb begin
        value_d = value_q;
        bad_d   = bad_q;
        count_d = count_q;
        if (accept) begin
            value_d = (value_q << 4) | W'(lookup_nib);
            bad_d   = bad_q | ~lookup_known;
            count_d = last_digit ? count_q : count_q + 1'b1;
        end else if (handshake) begin
            bad_d   = 1'b0;
            count_d = '0;
        end else if (timeout_expire) begin
            value_d = '0;
            bad_d   = 1'b0;
            count_d = '0;
        end
    end

    // Datapath registers
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            value_q <= '0;
            bad_q   <= 1'b0;
            count_q <= '0;
        end else begin
            value_q <= value_d;
            bad_q   <= bad_d;
            count_q <= count_d;
        end
    end

    assign value     = value_q;
    assign bad_digit = bad_q;

endmodule
